// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame defaults, the divider
// used by the external baud_generator, and the receiver state encoding.
package uart_rx_pkg;

  localparam int OVERSAMPLE_DEFAULT = 8;
  localparam int DATA_BITS_DEFAULT  = 8;
  localparam int CLK_HZ             = 50_000_000;
  localparam int BAUD_RATE          = 9600;

  // 50 MHz / (9600 * 8) truncates to 651, the RX baud_generator divider.
  localparam int BAUD_DIV = CLK_HZ / (BAUD_RATE * OVERSAMPLE_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous input; flops reset to 1
// so an idle-high line does not produce a spurious falling edge at reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_reg[0] <= 1'b1;
    else        chain_reg[0] <= async_in;
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_reg[gi] <= 1'b1;
        else        chain_reg[gi] <= chain_reg[gi-1];
      end
    end
  endgenerate

  assign sync_out = chain_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on an oversampled baud tick, with a one-entry holding
// register (valid/ready), framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_s_prev_reg;
  rx_state_t            state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 deliver_reg;
  logic                 frame_err_reg;
  logic                 busy_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 overrun_reg;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(rx_serial),
    .sync_out(rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s_prev_reg <= 1'b1;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      deliver_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      rx_s_prev_reg <= rx_s;
      deliver_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Edge-triggered so a line stuck low cannot restart the receiver.
          if (rx_s_prev_reg && !rx_s) begin
            state_reg <= ST_START;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            if (cnt_reg == CNT_MID) begin
              cnt_reg <= '0;
              if (!rx_s) begin
                state_reg <= ST_DATA;
                idx_reg   <= '0;
              end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (cnt_reg == CNT_LAST) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              cnt_reg   <= '0;
              if (idx_reg == IDX_LAST) begin
                state_reg <= ST_STOP;
                idx_reg   <= '0;
              end else begin
                idx_reg <= idx_reg + 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              cnt_reg   <= '0;
              if (rx_s) deliver_reg   <= 1'b1;
              else      frame_err_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // A pop in the same clk as a delivery frees the slot, so the new byte loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (deliver_reg && (!rx_valid_reg || rx_ready)) begin
        rx_data_reg  <= shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
      if (deliver_reg && rx_valid_reg && !rx_ready) overrun_reg <= 1'b1;
      else if (clr_err)                             overrun_reg <= 1'b0;
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: baud_tick every 4 clk, 32-clk serial bit period.
module tb_uart_rx;

  localparam int BIT_CLKS = 32;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready  = 1'b1;
  logic       clr_err   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         fe_cycles    = 0;
  int         tick_div     = 0;
  logic [7:0] rx_q[$];
  logic [7:0] got;

  uart_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_tick(baud_tick),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tick_div  = (tick_div + 1) % 4;
    baud_tick = (tick_div == 0);
  end

  // Record every completed handshake and every frame_err cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        rx_q.push_back(rx_data);
        $display("[TB] t=%0t received byte 0x%02h", $time, rx_data);
      end
      if (frame_err) fe_cycles++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    step(BIT_CLKS);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    $display("[TB] t=%0t send byte 0x%02h stop=%0b", $time, d, stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    fe_cycles = 0;
  endtask

  task automatic test_reset();
    step(3);
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    tests_run++;
    if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    step(8);
  endtask

  task automatic test_single();
    clear_obs();
    send_byte(8'hA5, 1'b1);
    step(BIT_CLKS);
    tests_run++;
    if (rx_q.size() !== 1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", rx_q.size()); end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    tests_run++;
    if (got !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h expected a5", got); end
    tests_run++;
    if (fe_cycles !== 0) begin tests_failed++; $display("FAIL single_frame_err: got %0d cycles expected 0", fe_cycles); end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL single_overrun: got %b expected 0", overrun); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy: got %b expected 0", busy); end
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL single_popped: got %b expected 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    step(BIT_CLKS);
    tests_run++;
    if (rx_q.size() !== 2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", rx_q.size()); end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    tests_run++;
    if (got !== 8'h00) begin tests_failed++; $display("FAIL b2b_first: got %h expected 00", got); end
    got = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
    tests_run++;
    if (got !== 8'hFF) begin tests_failed++; $display("FAIL b2b_second: got %h expected ff", got); end
  endtask

  task automatic test_glitch();
    clear_obs();
    $display("[TB] t=%0t glitch 8 clk low", $time);
    rx_serial = 1'b0;
    step(8);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_detected: got busy %b expected 1", busy); end
    rx_serial = 1'b1;
    step(BIT_CLKS - 8);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_idle: got busy %b expected 0", busy); end
    tests_run++;
    if (rx_q.size() !== 0) begin tests_failed++; $display("FAIL glitch_no_byte: got %0d expected 0", rx_q.size()); end
    tests_run++;
    if (fe_cycles !== 0) begin tests_failed++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cycles); end
  endtask

  task automatic test_frame_err();
    clear_obs();
    send_byte(8'h3C, 1'b0);
    step(3 * BIT_CLKS);
    tests_run++;
    if (fe_cycles !== 1) begin tests_failed++; $display("FAIL ferr_pulse: got %0d cycles expected 1", fe_cycles); end
    tests_run++;
    if (rx_q.size() !== 0) begin tests_failed++; $display("FAIL ferr_no_byte: got %0d expected 0", rx_q.size()); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_low_line: got busy %b expected 0", busy); end
    send_bit(1'b1);
    send_byte(8'h55, 1'b1);
    step(BIT_CLKS);
    tests_run++;
    if (rx_q.size() !== 1) begin tests_failed++; $display("FAIL ferr_recover_count: got %0d expected 1", rx_q.size()); end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    tests_run++;
    if (got !== 8'h55) begin tests_failed++; $display("FAIL ferr_recover_data: got %h expected 55", got); end
  endtask

  task automatic test_overrun();
    clear_obs();
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    step(BIT_CLKS);
    tests_run++;
    if (rx_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
    tests_run++;
    if (rx_data !== 8'h11) begin tests_failed++; $display("FAIL ovr_data: got %h expected 11", rx_data); end
    tests_run++;
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    tests_run++;
    if (rx_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_hold: got %b expected 1", rx_valid); end
    rx_ready = 1'b1;
    step(1);
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_pop: got %b expected 0", rx_valid); end
    got = (rx_q.size() == 1) ? rx_q[0] : 8'hxx;
    tests_run++;
    if (got !== 8'h11) begin tests_failed++; $display("FAIL ovr_popped_byte: got %h expected 11 once", got); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h96;
    clear_obs();
    $display("[TB] t=%0t send byte 0x96 aborted by reset at bit 4", $time);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_serial = d[4];
    step(BIT_CLKS / 2);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests_run++;
    if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_rx_valid: got %b expected 0", rx_valid); end
    tests_run++;
    if ({frame_err, overrun} !== 2'b00) begin tests_failed++; $display("FAIL midrst_flags: got %b expected 00", {frame_err, overrun}); end
    step(4);
    rst_n = 1'b1;
    step(2 * BIT_CLKS);
    clear_obs();
    send_byte(8'h69, 1'b1);
    step(BIT_CLKS);
    tests_run++;
    if (rx_q.size() !== 1) begin tests_failed++; $display("FAIL midrst_count: got %0d expected 1", rx_q.size()); end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    tests_run++;
    if (got !== 8'h69) begin tests_failed++; $display("FAIL midrst_data: got %h expected 69", got); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
